icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache between the fetch stage's word-request port and the shared memory block's fetch port.
- Serves hits in the same cycle as the request, with no memory traffic.
- On a miss, refills one whole line through a sequential word handshake, then serves the request.
- Gives a flush control for fence.i and self-modifying code.

---
 rtl/icache_pkg.sv | 22 ++
 rtl/icache_tag_array.sv | 45 ++++
 rtl/icache_direct.sv | 135 +++++++++++++
 tb/tb_icache_direct.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared state type and field-width helpers for the direct-mapped icache
package icache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } icache_state_t;

  function automatic int icache_offw(input int words);
    return $clog2(words);
  endfunction

  function automatic int icache_idxw(input int lines);
    return $clog2(lines);
  endfunction

  // Byte-offset bits [1:0] are never part of the tag.
  function automatic int icache_tagw(input int lines, input int words);
    return 30 - $clog2(words) - $clog2(lines);
  endfunction

endpackage

// File: rtl/icache_tag_array.sv
// rtl/icache_tag_array.sv - valid/tag storage with combinational lookup and synchronous write/flush
module icache_tag_array
  import icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDXW  = 4,
  parameter int TAGW  = 24
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic [IDXW-1:0] rd_idx_i,
  input  logic [TAGW-1:0] rd_tag_i,
  output logic            hit_o,
  output logic [TAGW-1:0] rd_tag_o,
  input  logic            wr_en_i,
  input  logic [IDXW-1:0] wr_idx_i,
  input  logic [TAGW-1:0] wr_tag_i,
  input  logic            wr_valid_i
);

  logic [LINES-1:0] valid_q;
  logic [TAGW-1:0]  tag_q [LINES];

  // Flush wins over a same-cycle fill so a line finishing during a flush stays invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= wr_valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
    end
  end

  assign rd_tag_o = tag_q[rd_idx_i];
  assign hit_o    = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);

endmodule

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache with whole-line refill
module icache_direct
  import icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fe_req,
  input  logic [31:0] fe_addr,
  output logic        fe_ack,
  output logic [31:0] fe_data,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data
);

  localparam int OFFW = icache_offw(WORDS);
  localparam int IDXW = icache_idxw(LINES);
  localparam int TAGW = icache_tagw(LINES, WORDS);

  icache_state_t   state_q, state_d;
  logic [OFFW-1:0] cnt_q, cnt_d;
  logic [31:0]     base_q, base_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [TAGW-1:0] rtag_q, rtag_d;
  logic            discard_q, discard_d;
  logic [31:0]     data_q [LINES][WORDS];

  logic [OFFW-1:0] lk_off;
  logic [IDXW-1:0] lk_idx;
  logic [TAGW-1:0] lk_tag;
  logic            lk_hit;
  logic            last_word;
  logic            tag_we;
  logic            tag_wvalid;
  logic [TAGW-1:0] unused_rd_tag;
  logic            unused_addr_bits;

  assign lk_off           = fe_addr[2 +: OFFW];
  assign lk_idx           = fe_addr[2 + OFFW +: IDXW];
  assign lk_tag           = fe_addr[31 -: TAGW];
  assign unused_addr_bits = ^fe_addr[1:0];

  icache_tag_array #(
    .LINES(LINES),
    .IDXW (IDXW),
    .TAGW (TAGW)
  ) u_tags (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (flush),
    .rd_idx_i  (lk_idx),
    .rd_tag_i  (lk_tag),
    .hit_o     (lk_hit),
    .rd_tag_o  (unused_rd_tag),
    .wr_en_i   (tag_we),
    .wr_idx_i  (idx_q),
    .wr_tag_i  (rtag_q),
    .wr_valid_i(tag_wvalid)
  );

  assign last_word  = (cnt_q == OFFW'(WORDS - 1));
  assign tag_wvalid = !(discard_q || flush);

  assign fe_ack   = fe_req && (state_q == IDLE) && lk_hit;
  assign fe_data  = fe_ack ? data_q[lk_idx][lk_off] : '0;
  assign mem_req  = (state_q == REFILL);
  // Base has its offset bits cleared, so OR-ing the word offset never carries.
  assign mem_addr = mem_req ? (base_q | {{(30 - OFFW){1'b0}}, cnt_q, 2'b00}) : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    idx_d     = idx_q;
    rtag_d    = rtag_q;
    discard_d = discard_q;
    tag_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (fe_req && !lk_hit) begin
          base_d  = {fe_addr[31:2 + OFFW], {(OFFW + 2){1'b0}}};
          idx_d   = lk_idx;
          rtag_d  = lk_tag;
          cnt_d   = '0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (flush) begin
          discard_d = 1'b1;
        end
        if (mem_ack) begin
          if (last_word) begin
            tag_we    = 1'b1;
            discard_d = 1'b0;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + OFFW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      base_q    <= '0;
      idx_q     <= '0;
      rtag_q    <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      rtag_q    <= rtag_d;
      discard_q <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == REFILL) && mem_ack) begin
      data_q[idx_q][cnt_q] <= mem_data;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - directed and randomized bench for icache_direct against a line-level model
module tb_icache_direct;

  logic        clk = 1'b0;
  logic        reset;
  logic        fe_req;
  logic [31:0] fe_addr;
  logic        fe_ack;
  logic [31:0] fe_data;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;

  int checks   = 0;
  int failures = 0;
  int words    = 0;

  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_data  [16][4];

  always #5 clk = ~clk;

  icache_direct #(
    .LINES(16),
    .WORDS(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .fe_req  (fe_req),
    .fe_addr (fe_addr),
    .fe_ack  (fe_ack),
    .fe_data (fe_data),
    .flush   (flush),
    .mem_req (mem_req),
    .mem_addr(mem_addr),
    .mem_ack (mem_ack),
    .mem_data(mem_data)
  );

  function automatic logic [31:0] memval(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h11;
      32'h0000_0104: return 32'h22;
      32'h0000_0108: return 32'h33;
      32'h0000_010C: return 32'h44;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  function automatic int unsigned line_of(input logic [31:0] a);
    return (a / 16) % 16;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a / 256;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[line_of(a)] && (m_tag[line_of(a)] == tag_of(a));
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    return m_data[line_of(a)][(a / 4) % 4];
  endfunction

  task automatic model_flush();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One fetch; injections (flush/redirect/reset before word N's ack) apply to the first refill only.
  task automatic fetch(input logic [31:0] a, input bit flush_now = 1'b0, input int flush_w = -1,
                       input int redir_w = -1, input logic [31:0] redir_a = 32'h0, input int rst_w = -1);
    logic [31:0] cur;
    logic [31:0] base;
    bit          disc;
    bit          mh;
    int          lat;
    cur = a;
    @(negedge clk);
    fe_req  = 1'b1;
    fe_addr = a;
    flush   = flush_now;
    #1;
    for (int t = 0; t < 4; t++) begin
      mh = model_hit(cur);
      check("fe_ack", {31'b0, fe_ack}, {31'b0, mh});
      if (mh) begin
        check("hit_data", fe_data, model_word(cur));
        check("hit_no_mem_req", {31'b0, mem_req}, 32'd0);
        if (flush) model_flush();
        break;
      end
      check("miss_data_zero", fe_data, 32'd0);
      if (flush) model_flush();
      base = cur & 32'hFFFF_FFF0;
      disc = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      #1;
      for (int w = 0; w < 4; w++) begin
        if (t == 0 && w == rst_w) begin
          reset = 1'b1;
          #1;
          check("reset_mem_req", {31'b0, mem_req}, 32'd0);
          check("reset_mem_addr", mem_addr, 32'd0);
          model_flush();
          @(negedge clk);
          reset  = 1'b0;
          fe_req = 1'b0;
          return;
        end
        if (t == 0 && w == flush_w) begin
          flush = 1'b1;
          disc  = 1'b1;
          model_flush();
          check("flush_cycle_addr", mem_addr, base + 32'(4 * w));
          @(negedge clk);
          flush = 1'b0;
          #1;
        end
        if (t == 0 && w == redir_w) begin
          fe_addr = redir_a;
          cur     = redir_a;
        end
        lat = $urandom_range(0, 2);
        for (int k = 0; k < lat; k++) begin
          check("wait_addr", mem_addr, base + 32'(4 * w));
          @(negedge clk);
          #1;
        end
        check("refill_addr", mem_addr, base + 32'(4 * w));
        check("refill_req", {31'b0, mem_req}, 32'd1);
        check("refill_no_ack", {31'b0, fe_ack}, 32'd0);
        mem_ack  = 1'b1;
        mem_data = memval(base + 32'(4 * w));
        words++;
        @(negedge clk);
        mem_ack  = 1'b0;
        mem_data = $urandom;
        #1;
      end
      for (int w = 0; w < 4; w++) m_data[line_of(base)][w] = memval(base + 32'(4 * w));
      m_tag[line_of(base)]   = tag_of(base);
      m_valid[line_of(base)] = !disc;
    end
    @(negedge clk);
    fe_req = 1'b0;
    flush  = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    int          sel;
    reset    = 1'b1;
    fe_req   = 1'b0;
    fe_addr  = 32'h0;
    flush    = 1'b0;
    mem_ack  = 1'b0;
    mem_data = 32'h0;
    model_flush();
    #2;
    check("rst_fe_ack", {31'b0, fe_ack}, 32'd0);
    check("rst_fe_data", fe_data, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    words = 0;
    fetch(32'h0000_0104);
    check("cold_miss_words", words, 32'd4);
    fetch(32'h0000_010C);
    check("hit_words", words, 32'd4);

    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_flush();
    words = 0;
    fetch(32'h0000_0108);
    check("post_flush_words", words, 32'd4);

    words = 0;
    fetch(32'h0000_0504);
    fetch(32'h0000_0104);
    check("conflict_words", words, 32'd8);

    fetch(32'h0000_0104, 1'b1);
    words = 0;
    fetch(32'h0000_0104);
    check("flush_with_hit_words", words, 32'd4);

    words = 0;
    fetch(32'h0000_02C8, 1'b0, 1);
    check("midflush_words", words, 32'd8);

    fetch(32'h0000_0348);
    words = 0;
    fetch(32'h0000_0200, 1'b0, -1, 2, 32'h0000_0348);
    check("redirect_words", words, 32'd4);
    fetch(32'h0000_020C);
    check("redirect_line_valid", words, 32'd4);
    fetch(32'h0000_0104);
    fetch(32'h0000_0200, 1'b0, -1, 1, 32'h0000_0104);

    words = 0;
    fetch(32'hFFFF_FFF4);
    fetch(32'hFFFF_FFFC);
    check("wrap_words", words, 32'd4);

    @(negedge clk);
    mem_ack  = 1'b1;
    mem_data = 32'hDEAD_BEEF;
    #1;
    check("idle_ack_no_req", {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    fetch(32'hFFFF_FFF0);

    fetch(32'h0000_0104);
    fetch(32'h0000_0380, 1'b0, -1, -1, 32'h0, 2);
    words = 0;
    fetch(32'h0000_0104);
    check("reset_then_miss_words", words, 32'd4);

    for (int i = 0; i < 150; i++) begin
      ra  = 32'($urandom_range(0, 3)) * 256 + 32'($urandom_range(0, 15)) * 16 + 32'($urandom_range(0, 3)) * 4;
      sel = $urandom_range(0, 9);
      if (sel == 0) fetch(ra, 1'b1);
      else if (sel == 1) fetch(ra, 1'b0, $urandom_range(0, 3));
      else fetch(ra);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
